pipeline_stage_skid: RTL and testbench
======================================

PIPELINE_STAGE_SKID -- requirements
Module: pipeline_stage_skid

Parameters
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the payload data width in bits.
REQ-002 The block SHALL have parameter CTRL_W, default 9, giving the width in bits of the control-flag bundle.

Interface
REQ-003 clk  input  1  Stage clock; all registers SHALL update on the falling edge.
REQ-004 reset  input  1  Reset, asynchronous, active-low.
REQ-005 in_valid  input  1  Upstream holds a valid entry.
REQ-006 in_ready  output  1  Stage can accept an entry this cycle.
REQ-007 in_data  input  DATA_W  Upstream payload.
REQ-008 in_ctrl  input  CTRL_W  Upstream control flags.
REQ-009 flush  input  1  Discard all held entries.
REQ-010 out_valid  output  1  Stage presents a valid entry.
REQ-011 out_ready  input  1  Downstream accepts this cycle.
REQ-012 out_data  output  DATA_W  Presented payload.
REQ-013 out_ctrl  output  CTRL_W  Presented control flags, gated by out_valid.

Function
REQ-014 Accept SHALL be defined as in_valid & in_ready; pop SHALL be defined as out_valid & out_ready; both SHALL be sampled at the falling clk edge.
REQ-015 Storage SHALL be a main register (drives the outputs) plus one skid register, each holding {data, ctrl}.
REQ-016 The FSM SHALL have exactly three states: EMPTY, ONE (main full) and TWO (main and skid full).
REQ-017 in_ready SHALL be 1 in EMPTY and ONE and 0 in TWO, decoded from state only with no combinational path from out_ready.
REQ-018 out_valid SHALL be 1 in ONE and TWO and 0 in EMPTY.
REQ-019 EMPTY transitions: accept SHALL load main and go to ONE; otherwise the stage SHALL stay in EMPTY.
REQ-020 ONE transitions (both conditions are possible in the same cycle):
  - accept & !pop SHALL load skid and go to TWO.
  - pop & !accept SHALL go to EMPTY.
  - accept & pop SHALL load main and stay in ONE.
  - otherwise the stage SHALL hold.
REQ-021 TWO transitions: pop SHALL copy skid into main and go to ONE; otherwise the stage SHALL hold.
REQ-022 Entries SHALL leave the stage in arrival order, with no duplication and no loss.
REQ-023 Latency from accept in EMPTY to out_valid SHALL be one clk falling edge.
REQ-024 Sustained throughput SHALL be one entry per cycle while out_ready stays 1.
REQ-025 flush SHALL have priority over accept and pop: it SHALL force EMPTY and zero the ctrl field of both registers, and any same-cycle accept SHALL be discarded.
REQ-026 out_ctrl SHALL be all-zero whenever out_valid is 0, so that bubbles carry no side effects.
REQ-027 out_data SHALL retain its last value while out_valid is 0.
REQ-028 Simultaneous flush and out_ready SHALL count as no pop; only EMPTY results.

Reset
REQ-029 While reset is 0, state SHALL be EMPTY and both registers SHALL be all-zero.
REQ-030 While reset is 0, out_valid SHALL be 0, out_data and out_ctrl SHALL be 0, and in_ready SHALL be 1.
REQ-031 Reset asserted mid-operation SHALL drop held entries immediately, without waiting for a clk edge.
REQ-032 The first accept after reset release SHALL behave as accept in EMPTY.

Structure
REQ-033 The state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) and the default widths (DATA_W=32, CTRL_W=9) SHALL live in shared package pipeline_pkg.
REQ-034 The block SHALL be a single module with no sub-module.
REQ-035 The existing per-stage pipeline registers SHALL be replaceable by instances of this block, with the ctrl bundle mapped to their control bits.

Verification
REQ-036 Reset scenario: pulse reset low mid-cycle while in TWO -> out_valid=0, out_ctrl=0, in_ready=1 immediately.
REQ-037 Streaming scenario: out_ready=1, push 0x11..0x18 one per cycle -> out_data 0x11..0x18 in order, first one edge after accept, no gaps.
REQ-038 Backpressure scenario: push 0xA1, 0xA2 with out_ready=0 ->
  - in_ready=0 after the second accept;
  - releasing out_ready delivers 0xA1 then 0xA2.
REQ-039 Simultaneous scenario: in ONE holding 0xB1, accept 0xB2 with pop -> state stays ONE, out_data=0xB2 next edge.
REQ-040 Flush scenario: in TWO, assert flush together with in_valid carrying 0xC3 and ctrl=9'h1FF ->
  - next edge: EMPTY, out_valid=0, out_ctrl=0;
  - 0xC3 is never presented.
REQ-041 Randomized scenario: random in_valid/out_ready with 10% flush, checked against a reference queue -> zero order, loss or duplication errors.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline stage blocks.
//   stageState_e : occupancy of a two-entry skid stage
//   DefDataW     : default payload width
//   DefCtrlW     : default control-flag bundle width
package pipeline_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefCtrlW = 9;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } stageState_e;

endpackage

// File: rtl/pipeline_stage_skid.sv
// Registered pipeline stage with a one-entry skid buffer. All state updates on the
// falling edge of clk. in_ready is decoded from state only, so out_ready never
// reaches in_ready combinationally.
//
// Ports:
//   clk       : stage clock (falling edge active)
//   reset     : asynchronous active-low reset
//   in_valid  : upstream offers an entry
//   in_ready  : stage can accept an entry this cycle
//   in_data   : upstream payload
//   in_ctrl   : upstream control flags
//   flush     : discard all held entries (beats accept and pop)
//   out_valid : stage presents an entry
//   out_ready : downstream accepts this cycle
//   out_data  : presented payload (holds its last value while out_valid is 0)
//   out_ctrl  : presented control flags, zero while out_valid is 0
module pipeline_stage_skid
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned CTRL_W = DefCtrlW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
);

  stageState_e       stateQ, stateD;
  logic [DATA_W-1:0] mainDataQ, mainDataD;
  logic [CTRL_W-1:0] mainCtrlQ, mainCtrlD;
  logic [DATA_W-1:0] skidDataQ, skidDataD;
  logic [CTRL_W-1:0] skidCtrlQ, skidCtrlD;
  logic              accept;
  logic              pop;

  // Outputs decoded from state only.
  always_comb begin
    in_ready  = (stateQ != StTwo);
    out_valid = (stateQ == StOne) || (stateQ == StTwo);
    out_data  = mainDataQ;
    out_ctrl  = out_valid ? mainCtrlQ : '0;
  end

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_comb begin
    stateD    = stateQ;
    mainDataD = mainDataQ;
    mainCtrlD = mainCtrlQ;
    skidDataD = skidDataQ;
    skidCtrlD = skidCtrlQ;
    if (flush) begin
      // Data is kept so out_data holds its last value; ctrl is cleared so stale
      // flags can never resurface.
      stateD    = StEmpty;
      mainCtrlD = '0;
      skidCtrlD = '0;
    end else begin
      unique case (stateQ)
        StEmpty: begin
          if (accept) begin
            mainDataD = in_data;
            mainCtrlD = in_ctrl;
            stateD    = StOne;
          end
        end
        StOne: begin
          if (accept && pop) begin
            mainDataD = in_data;
            mainCtrlD = in_ctrl;
          end else if (accept) begin
            skidDataD = in_data;
            skidCtrlD = in_ctrl;
            stateD    = StTwo;
          end else if (pop) begin
            stateD = StEmpty;
          end
        end
        StTwo: begin
          if (pop) begin
            mainDataD = skidDataQ;
            mainCtrlD = skidCtrlQ;
            stateD    = StOne;
          end
        end
        default: stateD = StEmpty;
      endcase
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      stateQ    <= StEmpty;
      mainDataQ <= '0;
      mainCtrlQ <= '0;
      skidDataQ <= '0;
      skidCtrlQ <= '0;
    end else begin
      stateQ    <= stateD;
      mainDataQ <= mainDataD;
      mainCtrlQ <= mainCtrlD;
      skidDataQ <= skidDataD;
      skidCtrlQ <= skidCtrlD;
    end
  end

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Self-checking bench for pipeline_stage_skid: directed scenarios plus random
// traffic, all compared against a queue-based reference of the stage contents.
module tb_pipeline_stage_skid;
  import pipeline_pkg::*;

  localparam int unsigned DW = DefDataW;
  localparam int unsigned CW = DefCtrlW;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;

  pipeline_stage_skid #(
    .DATA_W(DW),
    .CTRL_W(CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;

  // Reference: entries currently held, oldest first, packed as {data, ctrl}.
  logic [DW+CW-1:0] refQ[$];
  logic [DW-1:0]    refShown;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic checkAll(input string tag);
    logic [DW+CW-1:0] head;
    logic [CW-1:0]    expCtrl;
    expCtrl = '0;
    if (refQ.size() != 0) begin
      head     = refQ[0];
      refShown = head[DW+CW-1:CW];
      expCtrl  = head[CW-1:0];
    end
    check({tag, ".out_valid"}, 64'(out_valid), 64'(refQ.size() != 0));
    check({tag, ".in_ready"},  64'(in_ready),  64'(refQ.size() < 2));
    check({tag, ".out_data"},  64'(out_data),  64'(refShown));
    check({tag, ".out_ctrl"},  64'(out_ctrl),  64'(expCtrl));
  endtask

  // Apply inputs for one cycle, advance through the falling edge, update the
  // reference and compare. Called just after a falling edge (or at start).
  task automatic step(input string tag, input logic iv, input logic [DW-1:0] d,
                      input logic [CW-1:0] c, input logic ordy, input logic fl);
    logic acc, pp;
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    acc = iv && (refQ.size() < 2);
    pp  = ordy && (refQ.size() != 0);
    @(negedge clk);
    #1;
    if (fl) refQ.delete();
    else begin
      if (pp) void'(refQ.pop_front());
      if (acc) refQ.push_back({d, c});
    end
    checkAll(tag);
  endtask

  task automatic idle(input string tag, input logic ordy);
    step(tag, 1'b0, '0, '0, ordy, 1'b0);
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    refShown  = '0;

    // Reset state.
    #12;
    checkAll("reset");
    reset = 1'b1;
    @(negedge clk);
    #1;

    // Streaming: one entry per edge, first visible one edge after accept.
    for (int i = 0; i < 8; i++) begin
      step("stream", 1'b1, DW'(32'h11 + i), CW'(i + 1), 1'b1, 1'b0);
      check("stream.data", 64'(out_data), 64'(32'h11 + i));
    end
    idle("stream.drain", 1'b1);
    check("stream.empty", 64'(out_valid), 64'd0);

    // Backpressure.
    step("bp1", 1'b1, 32'hA1, 9'h003, 1'b0, 1'b0);
    step("bp2", 1'b1, 32'hA2, 9'h004, 1'b0, 1'b0);
    check("bp.in_ready", 64'(in_ready), 64'd0);
    check("bp.head", 64'(out_data), 64'hA1);
    idle("bp.rel1", 1'b1);
    check("bp.second", 64'(out_data), 64'hA2);
    idle("bp.rel2", 1'b1);

    // Simultaneous accept and pop in ONE.
    step("sim1", 1'b1, 32'hB1, 9'h011, 1'b0, 1'b0);
    step("sim2", 1'b1, 32'hB2, 9'h012, 1'b1, 1'b0);
    check("sim.data", 64'(out_data), 64'hB2);
    check("sim.in_ready", 64'(in_ready), 64'd1);
    idle("sim.drain", 1'b1);

    // Flush in TWO with a same-cycle accept.
    step("fl1", 1'b1, 32'hC1, 9'h021, 1'b0, 1'b0);
    step("fl2", 1'b1, 32'hC2, 9'h022, 1'b0, 1'b0);
    step("fl3", 1'b1, 32'hC3, 9'h1FF, 1'b1, 1'b1);
    check("fl.valid", 64'(out_valid), 64'd0);
    check("fl.ctrl", 64'(out_ctrl), 64'd0);
    idle("fl.after", 1'b1);
    check("fl.noC3", 64'(out_valid), 64'd0);

    // Asynchronous reset while in TWO.
    step("rst1", 1'b1, 32'hD1, 9'h031, 1'b0, 1'b0);
    step("rst2", 1'b1, 32'hD2, 9'h032, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    refQ.delete();
    refShown = '0;
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.ctrl", 64'(out_ctrl), 64'd0);
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.data", 64'(out_data), 64'd0);
    #3;
    reset = 1'b1;
    @(negedge clk);
    #1;
    step("rst.first", 1'b1, 32'hD3, 9'h033, 1'b0, 1'b0);
    check("rst.first.data", 64'(out_data), 64'hD3);
    idle("rst.drain", 1'b1);

    // Random traffic with ~10% flush.
    for (int i = 0; i < 2000; i++) begin
      step("rand", 1'($urandom_range(0, 1)), DW'($urandom), CW'($urandom),
           1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
